// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU width constants and the memory arbiter state type
package cpu_defs_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    RESP   = 2'd3
  } memarb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - unified memory port between the arbiter (master) and memory (slave)
interface mem_arbiter_if #(
  parameter int ADDR_W = cpu_defs_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_defs_pkg::CPU_DATA_W
);

  logic                bus_req;
  logic                bus_we;
  logic [DATA_W/8-1:0] bus_be;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W-1:0]   bus_rdata;
  logic                bus_ready;
  logic                bus_err;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/memarb_watchdog.sv
// rtl/memarb_watchdog.sv - counts BUSY cycles; expire marks LIMIT cycles without a response
module memarb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic busy,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // count_q is the number of BUSY cycles already completed before this one
  assign expire = busy && (count_q == CNT_W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (busy && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises IF fetches and MEM data accesses onto one memory port
// MEMARB_TIMEOUT_EN adds a BUSY watchdog that forces completion with bus_err.
module mem_arbiter
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W         = CPU_ADDR_W,
  parameter int DATA_W         = CPU_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stallreq,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stallreq,
  input  logic                flush,
  mem_arbiter_if.master       bus
);

  memarb_state_t state_q, state_d;

  logic                dm_owner_q, dm_owner_d;
  logic                discard_q, discard_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [DATA_W/8-1:0] bus_be_q, bus_be_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                busy;
  logic                expire;

  assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);

`ifdef MEMARB_TIMEOUT_EN
  logic start;
  logic bus_err_q, bus_err_d;

  assign start     = (state_q == IDLE) && (state_d != IDLE);
  assign bus_err_d = busy && expire && !bus.bus_ready;

  memarb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .busy   (busy),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.bus_err = bus_err_q;
`else
  assign expire      = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dm_owner_d  = dm_owner_q;
    discard_d   = discard_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if (state_q == IDLE) begin
      discard_d = 1'b0;
      if (!flush && dm_req) begin
        state_d     = BUSY_D;
        dm_owner_d  = 1'b1;
        bus_req_d   = 1'b1;
        bus_we_d    = dm_we;
        bus_be_d    = dm_be;
        bus_addr_d  = dm_addr;
        bus_wdata_d = dm_wdata;
      end else if (!flush && if_req) begin
        state_d    = BUSY_I;
        dm_owner_d = 1'b0;
        bus_req_d  = 1'b1;
        bus_we_d   = 1'b0;
        bus_be_d   = '1;
        bus_addr_d = if_addr;
      end
    end else if (busy) begin
      // a flushed fetch still finishes on the bus; only its valid pulse is dropped
      if (state_q == BUSY_I && flush) begin
        discard_d = 1'b1;
      end
      if (bus.bus_ready || expire) begin
        bus_req_d = 1'b0;
        state_d   = RESP;
        if (dm_owner_q) begin
          dm_rdata_d = bus.bus_ready ? bus.bus_rdata : '0;
        end else begin
          if_rdata_d = bus.bus_ready ? bus.bus_rdata : '0;
        end
      end
    end else begin
      state_d   = IDLE;
      discard_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      dm_owner_q  <= 1'b0;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      dm_owner_q  <= dm_owner_d;
      discard_q   <= discard_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_valid    = (state_q == RESP) && !dm_owner_q && !discard_q;
  assign dm_valid    = (state_q == RESP) && dm_owner_q;
  assign if_stallreq = if_req & ~if_valid;
  assign dm_stallreq = dm_req & ~dm_valid;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a queued-wait memory model
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 8;

  typedef struct {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_txn_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stallreq;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [BW-1:0] dm_be = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          dm_stallreq;
  logic          flush = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .if_stallreq (if_stallreq),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_be       (dm_be),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_valid    (dm_valid),
    .dm_stallreq (dm_stallreq),
    .flush       (flush),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  // memory model: each bus transaction takes its wait-state count from wait_q
  logic [DW-1:0] mem [bit [AW-1:0]];
  int            wait_q[$];
  bus_txn_t      log_q[$];
  int            busy_cnt = 0;
  int            cur_wait = 0;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin : responder
    logic [DW-1:0] v;
    if (!resetn || !bus_if.bus_req) begin
      busy_cnt = 0;
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rdata = $urandom();
    end else begin
      if (busy_cnt == 0) begin
        cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        log_q.push_back('{bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata});
      end
      if (busy_cnt == cur_wait) begin
        bus_if.bus_ready = 1'b1;
        v = mem_read(bus_if.bus_addr);
        bus_if.bus_rdata = v;
        if (bus_if.bus_we) begin
          for (int b = 0; b < BW; b++) if (bus_if.bus_be[b]) v[8*b +: 8] = bus_if.bus_wdata[8*b +: 8];
          mem[bus_if.bus_addr] = v;
        end
      end else begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom();
      end
      busy_cnt++;
    end
  end

  task automatic test_reset();
    tests_run++; if ({bus_if.bus_req, if_valid, dm_valid, bus_if.bus_err, if_stallreq, dm_stallreq} !== 6'b0) begin tests_failed++; $display("FAIL rst_ctrl: got %b exp 000000", {bus_if.bus_req, if_valid, dm_valid, bus_if.bus_err, if_stallreq, dm_stallreq}); end
    tests_run++; if (if_rdata !== '0) begin tests_failed++; $display("FAIL rst_if_rdata: got %h exp 0", if_rdata); end
    tests_run++; if (dm_rdata !== '0) begin tests_failed++; $display("FAIL rst_dm_rdata: got %h exp 0", dm_rdata); end
    tests_run++; if ({bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr} !== '0) begin tests_failed++; $display("FAIL rst_bus_fields: got %h exp 0", {bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr}); end
    resetn = 1'b1;
    @(negedge clk);
    tests_run++; if (bus_if.bus_req !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_req: got %b exp 0", bus_if.bus_req); end
  endtask

  task automatic test_fetch_zero_wait();
    wait_q.push_back(0);
    mem[32'h10] = 32'h2408_0005;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    tests_run++; if ({if_stallreq, bus_if.bus_req} !== 2'b10) begin tests_failed++; $display("FAIL fzw_c0: got %b exp 10", {if_stallreq, bus_if.bus_req}); end
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'b10_1111) begin tests_failed++; $display("FAIL fzw_c1_ctrl: got %b exp 101111", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
    tests_run++; if (bus_if.bus_addr !== 32'h10) begin tests_failed++; $display("FAIL fzw_c1_addr: got %h exp 00000010", bus_if.bus_addr); end
    tests_run++; if ({if_stallreq, if_valid} !== 2'b10) begin tests_failed++; $display("FAIL fzw_c1_stall: got %b exp 10", {if_stallreq, if_valid}); end
    @(negedge clk);
    tests_run++; if ({if_valid, if_stallreq, bus_if.bus_req} !== 3'b100) begin tests_failed++; $display("FAIL fzw_c2_valid: got %b exp 100", {if_valid, if_stallreq, bus_if.bus_req}); end
    tests_run++; if (if_rdata !== 32'h2408_0005) begin tests_failed++; $display("FAIL fzw_c2_rdata: got %h exp 24080005", if_rdata); end
    if_req = 1'b0;
    @(negedge clk);
    tests_run++; if ({if_valid, bus_if.bus_req} !== 2'b00) begin tests_failed++; $display("FAIL fzw_c3_idle: got %b exp 00", {if_valid, bus_if.bus_req}); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] exp_i;
    wait_q.push_back(0); wait_q.push_back(0);
    exp_i = mem_read(32'h14);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'b11_1111) begin tests_failed++; $display("FAIL sim_c1_ctrl: got %b exp 111111", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
    tests_run++; if ({bus_if.bus_addr, bus_if.bus_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL sim_c1_fields: got %h exp 00000100deadbeef", {bus_if.bus_addr, bus_if.bus_wdata}); end
    tests_run++; if ({dm_stallreq, if_stallreq} !== 2'b11) begin tests_failed++; $display("FAIL sim_c1_stall: got %b exp 11", {dm_stallreq, if_stallreq}); end
    @(negedge clk);
    tests_run++; if ({dm_valid, if_valid, dm_stallreq, if_stallreq} !== 4'b1001) begin tests_failed++; $display("FAIL sim_c2_dvalid: got %b exp 1001", {dm_valid, if_valid, dm_stallreq, if_stallreq}); end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, if_stallreq} !== 2'b01) begin tests_failed++; $display("FAIL sim_c3_idle: got %b exp 01", {bus_if.bus_req, if_stallreq}); end
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {2'b10, 32'h14}) begin tests_failed++; $display("FAIL sim_c4_fetch: got %h exp 2_00000014", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr}); end
    @(negedge clk);
    tests_run++; if ({if_valid, if_stallreq} !== 2'b10) begin tests_failed++; $display("FAIL sim_c5_ivalid: got %b exp 10", {if_valid, if_stallreq}); end
    tests_run++; if (if_rdata !== exp_i) begin tests_failed++; $display("FAIL sim_c5_rdata: got %h exp %h", if_rdata, exp_i); end
    if_req = 1'b0;
  endtask

  task automatic test_wait_states();
    wait_q.push_back(3);
    mem[32'h200] = 32'h1234_5678;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h200; dm_wdata = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++; if ({bus_if.bus_req, bus_if.bus_we, dm_valid, bus_if.bus_addr} !== {3'b100, 32'h200}) begin tests_failed++; $display("FAIL ws_c%0d_hold: got %h exp 4_00000200", c, {bus_if.bus_req, bus_if.bus_we, dm_valid, bus_if.bus_addr}); end
    end
    @(negedge clk);
    tests_run++; if ({dm_valid, dm_stallreq, bus_if.bus_req} !== 3'b100) begin tests_failed++; $display("FAIL ws_c5_valid: got %b exp 100", {dm_valid, dm_stallreq, bus_if.bus_req}); end
    tests_run++; if (dm_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL ws_c5_rdata: got %h exp 12345678", dm_rdata); end
    dm_req = 1'b0;
  endtask

  task automatic test_flush_fetch();
    logic [DW-1:0] exp_d;
    wait_q.push_back(1); wait_q.push_back(0);
    exp_d = mem_read(32'h50);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_c1_valid: got %b exp 0", if_valid); end
    flush = 1'b1;
    @(negedge clk);
    tests_run++; if ({if_valid, bus_if.bus_req} !== 2'b01) begin tests_failed++; $display("FAIL fl_c2: got %b exp 01", {if_valid, bus_if.bus_req}); end
    flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    tests_run++; if ({if_valid, bus_if.bus_req} !== 2'b00) begin tests_failed++; $display("FAIL fl_c3_resp: got %b exp 00", {if_valid, bus_if.bus_req}); end
    @(negedge clk);
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_c4_valid: got %b exp 0", if_valid); end
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h50;
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h50}) begin tests_failed++; $display("FAIL fl_c5_grant: got %h exp 1_00000050", {bus_if.bus_req, bus_if.bus_addr}); end
    @(negedge clk);
    tests_run++; if ({dm_valid, dm_rdata} !== {1'b1, exp_d}) begin tests_failed++; $display("FAIL fl_c6_dvalid: got %h exp 1_%h", {dm_valid, dm_rdata}, exp_d); end
    dm_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [DW-1:0] exp_d;
    wait_q.push_back(20);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300;
    repeat (2) @(negedge clk);
    dm_req = 1'b0;
    resetn = 1'b0;
    #1;
    tests_run++; if ({bus_if.bus_req, dm_valid, if_valid, bus_if.bus_err} !== 4'b0) begin tests_failed++; $display("FAIL rma_ctrl: got %b exp 0000", {bus_if.bus_req, dm_valid, if_valid, bus_if.bus_err}); end
    tests_run++; if ({dm_rdata, if_rdata} !== '0) begin tests_failed++; $display("FAIL rma_rdata: got %h exp 0", {dm_rdata, if_rdata}); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_q.push_back(0);
    exp_d = mem_read(32'h304);
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h304;
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h304}) begin tests_failed++; $display("FAIL rma_regrant: got %h exp 1_00000304", {bus_if.bus_req, bus_if.bus_addr}); end
    @(negedge clk);
    tests_run++; if ({dm_valid, dm_rdata} !== {1'b1, exp_d}) begin tests_failed++; $display("FAIL rma_done: got %h exp 1_%h", {dm_valid, dm_rdata}, exp_d); end
    dm_req = 1'b0;
  endtask

`ifdef MEMARB_TIMEOUT_EN
  task automatic test_timeout();
    wait_q.push_back(1000);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h400;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      tests_run++; if ({bus_if.bus_req, dm_valid, bus_if.bus_err} !== 3'b100) begin tests_failed++; $display("FAIL tmo_c%0d_busy: got %b exp 100", c, {bus_if.bus_req, dm_valid, bus_if.bus_err}); end
    end
    @(negedge clk);
    tests_run++; if ({bus_if.bus_req, dm_valid, bus_if.bus_err} !== 3'b011) begin tests_failed++; $display("FAIL tmo_expire: got %b exp 011", {bus_if.bus_req, dm_valid, bus_if.bus_err}); end
    tests_run++; if (dm_rdata !== '0) begin tests_failed++; $display("FAIL tmo_rdata: got %h exp 0", dm_rdata); end
    dm_req = 1'b0;
    @(negedge clk);
    tests_run++; if ({dm_valid, bus_if.bus_err} !== 2'b00) begin tests_failed++; $display("FAIL tmo_pulse: got %b exp 00", {dm_valid, bus_if.bus_err}); end
  endtask
`endif

  // Reference: data completes at wait+2; a fetch behind it is granted one idle cycle after the data RESP.
  task automatic test_random();
    wait_q.delete();
    log_q.delete();
    for (int it = 0; it < 40; it++) begin
      bit do_d, do_i, got_d, got_i;
      int wd, wi, t_d, t_i;
      logic [DW-1:0] exp_d, exp_i;
      bus_txn_t tx;
      do_d = ($urandom_range(0, 1) == 1);
      do_i = ($urandom_range(0, 1) == 1) || !do_d;
      wd = $urandom_range(0, 3);
      wi = $urandom_range(0, 3);
      t_d = wd + 2;
      t_i = do_d ? (wd + 3) + wi + 2 : wi + 2;
      got_d = 1'b0; got_i = 1'b0;
      @(negedge clk);
      dm_we = ($urandom_range(0, 1) == 1); dm_be = 4'($urandom_range(0, 15));
      dm_addr = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC; dm_wdata = $urandom();
      if_addr = $urandom() & 32'h7FFF_FFFC;
      exp_d = mem_read(dm_addr);
      exp_i = mem_read(if_addr);
      if (do_d) wait_q.push_back(wd);
      if (do_i) wait_q.push_back(wi);
      dm_req = do_d; if_req = do_i;
      for (int c = 1; c <= 20 && !(got_d == do_d && got_i == do_i); c++) begin
        @(negedge clk);
        tests_run++; if (dm_stallreq !== (do_d && !got_d && c != t_d)) begin tests_failed++; $display("FAIL rnd%0d_c%0d_dstall: got %b", it, c, dm_stallreq); end
        tests_run++; if (if_stallreq !== (do_i && !got_i && c != t_i)) begin tests_failed++; $display("FAIL rnd%0d_c%0d_istall: got %b", it, c, if_stallreq); end
        tests_run++; if ({dm_valid, if_valid, bus_if.bus_err} !== {(do_d && c == t_d), (do_i && c == t_i), 1'b0}) begin tests_failed++; $display("FAIL rnd%0d_c%0d_valid: got %b exp %b", it, c, {dm_valid, if_valid, bus_if.bus_err}, {(do_d && c == t_d), (do_i && c == t_i), 1'b0}); end
        if (dm_valid) begin
          tests_run++; if (dm_rdata !== exp_d) begin tests_failed++; $display("FAIL rnd%0d_drdata: got %h exp %h", it, dm_rdata, exp_d); end
          got_d = 1'b1; dm_req = 1'b0;
        end
        if (if_valid) begin
          tests_run++; if (if_rdata !== exp_i) begin tests_failed++; $display("FAIL rnd%0d_irdata: got %h exp %h", it, if_rdata, exp_i); end
          got_i = 1'b1; if_req = 1'b0;
        end
      end
      tests_run++; if ({got_d, got_i} !== {do_d, do_i}) begin tests_failed++; $display("FAIL rnd%0d_done: got %b exp %b", it, {got_d, got_i}, {do_d, do_i}); end
      dm_req = 1'b0; if_req = 1'b0;
      if (do_d) begin
        tests_run++;
        if (log_q.size() == 0) begin tests_failed++; $display("FAIL rnd%0d_dbus: got no bus transaction exp one", it); end
        else begin
          tx = log_q.pop_front();
          if ({tx.we, tx.be, tx.addr, tx.wdata} !== {dm_we, dm_be, dm_addr, dm_wdata}) begin tests_failed++; $display("FAIL rnd%0d_dbus: got %h exp %h", it, {tx.we, tx.be, tx.addr, tx.wdata}, {dm_we, dm_be, dm_addr, dm_wdata}); end
        end
      end
      if (do_i) begin
        tests_run++;
        if (log_q.size() == 0) begin tests_failed++; $display("FAIL rnd%0d_ibus: got no bus transaction exp one", it); end
        else begin
          tx = log_q.pop_front();
          if ({tx.we, tx.be, tx.addr} !== {1'b0, 4'hF, if_addr}) begin tests_failed++; $display("FAIL rnd%0d_ibus: got %h exp %h", it, {tx.we, tx.be, tx.addr}, {1'b0, 4'hF, if_addr}); end
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_fetch_zero_wait();
    test_simultaneous();
    test_wait_states();
    test_flush_fetch();
    test_reset_mid_access();
`ifdef MEMARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish exp finish");
    $fatal(1);
  end

endmodule
